// File: rtl/if_inst_buffer.sv
// Fetch-to-decode show-ahead instruction buffer with NOP bubble insertion on empty.
// Optional zero-latency empty-path forwarding is built when IBUF_BYPASS_EN is defined.
module if_inst_buffer #(
    parameter int DEPTH = 4,
    parameter int PTR_W = 2
) (
    input  logic             clk_i,
    input  logic             reset_i,
    input  logic             fetch_valid_i,
    input  logic [31:0]      fetch_inst_i,
    input  logic [31:0]      fetch_pc_i,
    output logic             fetch_ready_o,
    input  logic             stall_ID,
    input  logic             kill_IF,
    output logic [31:0]      inst1_o,
    output logic [31:0]      pc1_o,
    output logic             inst1_valid_o,
    output logic [PTR_W:0]   count_o
);

    localparam logic [31:0]    NOP_INST   = 32'h0000_0013;
    localparam logic [PTR_W:0] FULL_COUNT = (PTR_W + 1)'(DEPTH);

    logic [31:0]      inst_mem [DEPTH];
    logic [31:0]      pc_mem   [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic [PTR_W:0]   count;

    logic             stored_valid;
    logic             enq;
    logic             deq;
    logic             bypass_take;

    // Handshake: fetch transfers on fetch_valid_i & fetch_ready_o (ready never
    // depends on this cycle's dequeue); decode consumes on inst1_valid_o & ~stall_ID;
    // kill_IF cancels both sides of the cycle.
    assign fetch_ready_o = ~reset_i & (count != FULL_COUNT);
    assign stored_valid  = (count != '0);
    assign count_o       = count;

`ifdef IBUF_BYPASS_EN
    logic bypass_show;

    assign bypass_show = ~stored_valid & fetch_valid_i & ~reset_i;
    assign bypass_take = bypass_show & ~stall_ID & ~kill_IF;

    always_comb begin
        inst1_valid_o = 1'b0;
        inst1_o       = NOP_INST;
        pc1_o         = 32'h0;
        if (stored_valid) begin
            inst1_valid_o = 1'b1;
            inst1_o       = inst_mem[rd_ptr];
            pc1_o         = pc_mem[rd_ptr];
        end else if (bypass_show) begin
            inst1_valid_o = 1'b1;
            inst1_o       = fetch_inst_i;
            pc1_o         = fetch_pc_i;
        end
    end
`else
    assign bypass_take = 1'b0;

    always_comb begin
        inst1_valid_o = 1'b0;
        inst1_o       = NOP_INST;
        pc1_o         = 32'h0;
        if (stored_valid) begin
            inst1_valid_o = 1'b1;
            inst1_o       = inst_mem[rd_ptr];
            pc1_o         = pc_mem[rd_ptr];
        end
    end
`endif

    // A forwarded offer is consumed straight from the fetch inputs, never stored.
    assign enq = fetch_valid_i & fetch_ready_o & ~kill_IF & ~bypass_take;
    assign deq = stored_valid & ~stall_ID & ~kill_IF;

    always_ff @(posedge clk_i) begin
        if (enq) begin
            inst_mem[wr_ptr] <= fetch_inst_i;
            pc_mem[wr_ptr]   <= fetch_pc_i;
        end
    end

    always_ff @(posedge clk_i) begin
        if (reset_i || kill_IF) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (enq) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (deq) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({enq, deq})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

endmodule
